// File: rtl/instruction_decode_if.sv
// IF/ID inputs, write-back port and ID/EX outputs of the RV32I decode stage.
// slave = decode stage side, master = surrounding pipeline side.
interface instruction_decode_if;
    logic [31:0] PIP_instruction_i;
    logic [31:0] PIP_pc_i;
    logic        flush_i;
    logic        wb_we_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        stall_if_o;
    logic        PIP_valid_o;
    logic [31:0] PIP_pc_o;
    logic [31:0] PIP_rs1_data_o;
    logic [31:0] PIP_rs2_data_o;
    logic [31:0] PIP_imm_o;
    logic [4:0]  PIP_rs1_o;
    logic [4:0]  PIP_rs2_o;
    logic [4:0]  PIP_rd_o;
    logic [6:0]  PIP_opcode_o;
    logic [2:0]  PIP_funct3_o;
    logic        PIP_funct7b5_o;
    logic        PIP_mem_read_o;
    logic        PIP_reg_write_o;

    modport slave (
        input  PIP_instruction_i, PIP_pc_i, flush_i, wb_we_i, wb_rd_i, wb_data_i,
        output stall_if_o, PIP_valid_o, PIP_pc_o, PIP_rs1_data_o, PIP_rs2_data_o,
               PIP_imm_o, PIP_rs1_o, PIP_rs2_o, PIP_rd_o, PIP_opcode_o,
               PIP_funct3_o, PIP_funct7b5_o, PIP_mem_read_o, PIP_reg_write_o
    );

    modport master (
        output PIP_instruction_i, PIP_pc_i, flush_i, wb_we_i, wb_rd_i, wb_data_i,
        input  stall_if_o, PIP_valid_o, PIP_pc_o, PIP_rs1_data_o, PIP_rs2_data_o,
               PIP_imm_o, PIP_rs1_o, PIP_rs2_o, PIP_rd_o, PIP_opcode_o,
               PIP_funct3_o, PIP_funct7b5_o, PIP_mem_read_o, PIP_reg_write_o
    );
endinterface

// File: rtl/instruction_decode.sv
// RV32I decode stage: register file, field/immediate decode, load-use stall, ID/EX register.
// Optional macro ID_WB_BYPASS_EN makes a same-cycle write-back visible to decode reads.
module instruction_decode (
    input  logic                  clk,
    input  logic                  reset_n,
    instruction_decode_if.slave   bus
);
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic        mem_read;
        logic        reg_write;
    } id_ex_t;

    logic [31:0] regs_q [0:31];
    id_ex_t      id_ex_q, id_ex_d;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        rs1_used, rs2_used, writes_rd, hazard;
    logic [31:0] rs1_data, rs2_data;

    // x0 is never written, so it holds the reset value 0.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_reg
            always_ff @(posedge clk) begin
                if (!reset_n)
                    regs_q[gi] <= '0;
                else if (bus.wb_we_i && bus.wb_rd_i == 5'(gi) && gi != 0)
                    regs_q[gi] <= bus.wb_data_i;
            end
        end
    endgenerate

    assign instr  = bus.PIP_instruction_i;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

`ifdef ID_WB_BYPASS_EN
    assign rs1_data = (rs1 == 5'd0) ? '0 :
                      (bus.wb_we_i && bus.wb_rd_i == rs1) ? bus.wb_data_i : regs_q[rs1];
    assign rs2_data = (rs2 == 5'd0) ? '0 :
                      (bus.wb_we_i && bus.wb_rd_i == rs2) ? bus.wb_data_i : regs_q[rs2];
`else
    assign rs1_data = (rs1 == 5'd0) ? '0 : regs_q[rs1];
    assign rs2_data = (rs2 == 5'd0) ? '0 : regs_q[rs2];
`endif

    always_comb begin
        imm       = '0;
        rs1_used  = 1'b1;
        rs2_used  = 1'b0;
        writes_rd = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
                imm       = {{20{instr[31]}}, instr[31:20]};
                writes_rd = 1'b1;
            end
            OPC_STORE: begin
                imm      = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                rs2_used = 1'b1;
            end
            OPC_BRANCH: begin
                imm      = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                rs2_used = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm       = {instr[31:12], 12'b0};
                rs1_used  = 1'b0;
                writes_rd = 1'b1;
            end
            OPC_JAL: begin
                imm       = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                rs1_used  = 1'b0;
                writes_rd = 1'b1;
            end
            OPC_OP: begin
                rs2_used  = 1'b1;
                writes_rd = 1'b1;
            end
            default: ;
        endcase
    end

    // Only a load still sitting in ID/EX can create a dependency that EX forwarding cannot cover.
    assign hazard = id_ex_q.valid && id_ex_q.mem_read && (id_ex_q.rd != 5'd0) &&
                    ((rs1_used && rs1 == id_ex_q.rd) || (rs2_used && rs2 == id_ex_q.rd));

    always_comb begin
        id_ex_d = '0;
        if (!bus.flush_i && !hazard && instr != 32'd0) begin
            id_ex_d.valid     = 1'b1;
            id_ex_d.pc        = bus.PIP_pc_i;
            id_ex_d.rs1_data  = rs1_data;
            id_ex_d.rs2_data  = rs2_data;
            id_ex_d.imm       = imm;
            id_ex_d.rs1       = rs1;
            id_ex_d.rs2       = rs2;
            id_ex_d.rd        = rd;
            id_ex_d.opcode    = opcode;
            id_ex_d.funct3    = instr[14:12];
            id_ex_d.funct7b5  = instr[30];
            id_ex_d.mem_read  = (opcode == OPC_LOAD);
            id_ex_d.reg_write = writes_rd && (rd != 5'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            id_ex_q <= '0;
        else
            id_ex_q <= id_ex_d;
    end

    assign bus.stall_if_o      = hazard && !bus.flush_i;
    assign bus.PIP_valid_o     = id_ex_q.valid;
    assign bus.PIP_pc_o        = id_ex_q.pc;
    assign bus.PIP_rs1_data_o  = id_ex_q.rs1_data;
    assign bus.PIP_rs2_data_o  = id_ex_q.rs2_data;
    assign bus.PIP_imm_o       = id_ex_q.imm;
    assign bus.PIP_rs1_o       = id_ex_q.rs1;
    assign bus.PIP_rs2_o       = id_ex_q.rs2;
    assign bus.PIP_rd_o        = id_ex_q.rd;
    assign bus.PIP_opcode_o    = id_ex_q.opcode;
    assign bus.PIP_funct3_o    = id_ex_q.funct3;
    assign bus.PIP_funct7b5_o  = id_ex_q.funct7b5;
    assign bus.PIP_mem_read_o  = id_ex_q.mem_read;
    assign bus.PIP_reg_write_o = id_ex_q.reg_write;
endmodule
